decode_stage_hs: RTL and testbench
==================================

Name: decode_stage_hs

Overview:
- Parametrised successor to the MIPS ID stage: decodes one 32-bit instruction per cycle, reads an internal register file with write-through bypass, and registers the ID/EX fields.
- Adds valid/ready handshaking to IF and EX, a load-use stall FSM, early jump/jump-register resolution, and a sticky halt state.
- Sits between the IF/ID latch and the execute stage.

Parameters:
- LEN, 32, datapath and register width (≥32).
- NREG, 32, register file depth (power of 2, ≤32).
- NB, $clog2(NREG), register index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  IF/ID holds a valid instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_pc  in  LEN  PC+4 of the instruction.
- in_instr  in  32  instruction word.
- flush  in  1  squash the stage contents (branch taken in a later stage).
- wb_we  in  1  write-back enable.
- wb_addr  in  NB  write-back register index.
- wb_data  in  LEN  write-back data.
- out_valid  out  1  ID/EX holds a valid instruction.
- out_ready  in  1  EX accepts ID/EX this cycle.
- out_pc, out_rs_val, out_rt_val, out_imm  out  LEN  registered fields; out_imm is sign-extended imm16.
- out_rs, out_rt, out_rd, out_shamt  out  NB/NB/NB/5  registered indices.
- out_ctrl  out  9  registered control bits {link,jump,branch,mem_to_reg,reg_write,mem_write,mem_read,alu_src,reg_dst}.
- jump_taken  out  1  combinational; a J, JAL or JR is accepted this cycle.
- jump_target  out  LEN  {in_pc[LEN-1:28], instr[25:0], 2'b00} for J/JAL; bypassed rs value for JR.
- halted  out  1  stage has accepted a HALT.

Behaviour:
- Reset: all outputs 0, register file cleared, FSM = RUN. Reset taking effect mid-stall or mid-halt returns the stage to RUN with out_valid = 0.
- Register file:
  - Register 0 always reads 0; writes to index 0 are ignored.
  - Write-through bypass: if wb_we and wb_addr == the read index (≠0), the read returns wb_data in the same cycle.
- Decode (opcode in instr[31:26]):
  - 0x00 R-type: reg_dst, reg_write. funct 0x08 = JR: no reg_write, sets jump.
  - 0x23 LW: alu_src, mem_read, mem_to_reg, reg_write.
  - 0x2B SW: alu_src, mem_write.
  - 0x04/0x05 BEQ/BNE: branch.
  - 0x08 ADDI: alu_src, reg_write.
  - 0x02 J: jump. 0x03 JAL: jump, link, reg_write; out_rd forced to NREG-1.
  - 0x3F HALT: all control bits 0.
  - Any other opcode: all control bits 0 (NOP).
- Handshake:
  - Transfer from IF happens when in_valid && in_ready.
  - ID/EX advances when out_ready || !out_valid. When it does not advance, all out_* fields hold.
- Load-use hazard:
  - Condition: out_valid && out_ctrl.mem_read && out_rt ≠ 0 && out_rt equals instr rs, or equals instr rt for R-type/SW/BEQ/BNE.
  - Response: FSM goes RUN → STALL; in_ready = 0; a bubble is loaded (out_valid ← 0).
  - STALL → RUN after exactly one bubble has been loaded. The instruction is then re-decoded with bypass.
- in_ready = (FSM == RUN) && !hazard && !halted && (out_ready || !out_valid).
- jump_taken = in_valid && in_ready && !flush && ctrl.jump.
- Flush: synchronous; highest priority after reset.
  - out_valid ← 0, out_ctrl ← 0, FSM ← RUN, jump_taken forced 0.
  - A concurrent register write still occurs.
- HALT:
  - When accepted, it is passed downstream once with out_valid = 1.
  - FSM → HALTED and halted = 1. in_ready stays 0 until reset; flush does not clear it.
  - ID/EX drains normally.
- Simultaneous wb write and load-use stall: the write lands; the re-decode after STALL sees the new value.
- Latency: 1 cycle from acceptance to out_valid.

Test Plan:
- wb write r5 = 0x1234 and a read of rs = 5 in the same cycle -> out_rs_val = 0x1234 next cycle; wb write to r0 = 0xFFFF -> reads of r0 return 0.
- LW r3,0(r1) followed by ADD r4,r3,r2 with out_ready = 1 -> exactly one cycle with in_ready = 0 and one bubble (out_valid = 0), then ADD is issued with out_rs = 3.
- J 0x0000040 with in_pc = 0x10000004 -> jump_taken = 1, jump_target = 0x10000100; JR r7 with r7 = 0x200 -> jump_target = 0x200.
- out_ready held 0 for 3 cycles with in_valid = 1 -> in_ready = 0 throughout and out_* fields stable; the next instruction is accepted in the cycle out_ready returns to 1.
- flush asserted during a STALL -> out_valid = 0 next cycle, FSM = RUN, jump_taken = 0 during flush.
- HALT, then further instructions -> HALT is output once, halted = 1, in_ready stays 0; reset pulse -> halted = 0, all outputs 0.

Source files
------------

// File: rtl/decode_stage_hs.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decode_stage_hs : handshaked ID stage with regfile bypass, load-use stall,
//                   early J/JR resolution and sticky halt.  Rev 1.0
// ---------------------------------------------------------------------------
module decode_stage_hs #(
  parameter int LEN  = 32,
  parameter int NREG = 32,
  parameter int NB   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [LEN-1:0]  in_pc,
  input  logic [31:0]     in_instr,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [NB-1:0]   wb_addr,
  input  logic [LEN-1:0]  wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [LEN-1:0]  out_pc,
  output logic [LEN-1:0]  out_rs_val,
  output logic [LEN-1:0]  out_rt_val,
  output logic [LEN-1:0]  out_imm,
  output logic [NB-1:0]   out_rs,
  output logic [NB-1:0]   out_rt,
  output logic [NB-1:0]   out_rd,
  output logic [4:0]      out_shamt,
  output logic [8:0]      out_ctrl,
  output logic            jump_taken,
  output logic [LEN-1:0]  jump_target,
  output logic            halted
);

  localparam int C_LINK      = 8;
  localparam int C_JUMP      = 7;
  localparam int C_BRANCH    = 6;
  localparam int C_MEM2REG   = 5;
  localparam int C_REG_WRITE = 4;
  localparam int C_MEM_WRITE = 3;
  localparam int C_MEM_READ  = 2;
  localparam int C_ALU_SRC   = 1;
  localparam int C_REG_DST   = 0;
  localparam logic [NB-1:0] LAST_REG = NB'(NREG - 1);

  typedef enum logic [1:0] {S_RUN = 2'd0, S_STALL = 2'd1, S_HALTED = 2'd2} state_t;
  state_t state, state_nx;

  logic [LEN-1:0] regs [NREG];

  logic [5:0]     opcode, funct;
  logic [NB-1:0]  rs_idx, rt_idx, rd_idx, rd_dec;
  logic [LEN-1:0] rs_val, rt_val, imm_ext;
  logic [8:0]     ctrl;
  logic           is_jr, is_halt, uses_rt;
  logic           hazard, advance, accept, take;

  assign opcode  = in_instr[31:26];
  assign funct   = in_instr[5:0];
  assign rs_idx  = in_instr[21 +: NB];
  assign rt_idx  = in_instr[16 +: NB];
  assign rd_idx  = in_instr[11 +: NB];
  assign imm_ext = {{(LEN-16){in_instr[15]}}, in_instr[15:0]};

  always_comb begin
    ctrl    = '0;
    is_jr   = 1'b0;
    is_halt = 1'b0;
    uses_rt = 1'b0;
    case (opcode)
      6'h00: begin
        uses_rt = 1'b1;
        ctrl[C_REG_DST] = 1'b1;
        if (funct == 6'h08) begin
          is_jr = 1'b1;
          ctrl[C_JUMP] = 1'b1;
        end else begin
          ctrl[C_REG_WRITE] = 1'b1;
        end
      end
      6'h23: begin
        ctrl[C_ALU_SRC]   = 1'b1;
        ctrl[C_MEM_READ]  = 1'b1;
        ctrl[C_MEM2REG]   = 1'b1;
        ctrl[C_REG_WRITE] = 1'b1;
      end
      6'h2B: begin
        uses_rt = 1'b1;
        ctrl[C_ALU_SRC]   = 1'b1;
        ctrl[C_MEM_WRITE] = 1'b1;
      end
      6'h04, 6'h05: begin
        uses_rt = 1'b1;
        ctrl[C_BRANCH] = 1'b1;
      end
      6'h08: begin
        ctrl[C_ALU_SRC]   = 1'b1;
        ctrl[C_REG_WRITE] = 1'b1;
      end
      6'h02: ctrl[C_JUMP] = 1'b1;
      6'h03: begin
        ctrl[C_JUMP]      = 1'b1;
        ctrl[C_LINK]      = 1'b1;
        ctrl[C_REG_WRITE] = 1'b1;
      end
      6'h3F: is_halt = 1'b1;
      default: ctrl = '0;
    endcase
  end

  assign rd_dec = (opcode == 6'h03) ? LAST_REG : rd_idx;

  // Same-cycle write-back is forwarded so the ID stage never reads stale data.
  assign rs_val = (rs_idx == '0) ? '0 :
                  (wb_we && wb_addr == rs_idx) ? wb_data : regs[rs_idx];
  assign rt_val = (rt_idx == '0) ? '0 :
                  (wb_we && wb_addr == rt_idx) ? wb_data : regs[rt_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_we && wb_addr != '0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  assign hazard  = out_valid && out_ctrl[C_MEM_READ] && (out_rt != '0) &&
                   ((out_rt == rs_idx) || (uses_rt && out_rt == rt_idx));
  assign advance = out_ready || !out_valid;
  assign halted  = (state == S_HALTED);
  assign in_ready = (state == S_RUN) && !hazard && !halted && advance;
  assign accept  = in_valid && in_ready;
  assign take    = accept && !flush;

  assign jump_taken  = take && ctrl[C_JUMP];
  assign jump_target = is_jr ? rs_val : {in_pc[LEN-1:28], in_instr[25:0], 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RUN;
    else       state <= state_nx;
  end

  // A hazard seen while ID/EX can advance loads its single bubble on that
  // same edge, so STALL is only entered when the bubble has to wait.
  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = (state == S_HALTED) ? S_HALTED : S_RUN;
    end else begin
      case (state)
        S_RUN: begin
          if (take && is_halt)                   state_nx = S_HALTED;
          else if (in_valid && hazard && !advance) state_nx = S_STALL;
        end
        S_STALL:  if (advance) state_nx = S_RUN;
        S_HALTED: state_nx = S_HALTED;
        default:  state_nx = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_pc     <= '0;
      out_rs_val <= '0;
      out_rt_val <= '0;
      out_imm    <= '0;
      out_rs     <= '0;
      out_rt     <= '0;
      out_rd     <= '0;
      out_shamt  <= '0;
      out_ctrl   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
    end else if (advance) begin
      out_valid <= accept;
      out_ctrl  <= accept ? ctrl : '0;
      if (accept) begin
        out_pc     <= in_pc;
        out_rs_val <= rs_val;
        out_rt_val <= rt_val;
        out_imm    <= imm_ext;
        out_rs     <= rs_idx;
        out_rt     <= rt_idx;
        out_rd     <= rd_dec;
        out_shamt  <= in_instr[10:6];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_hs.sv
`default_nettype none
// Scoreboard bench for decode_stage_hs: directed vectors, queued expectations.
module tb_decode_stage_hs;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, flush, wb_we, out_valid, out_ready;
  logic        jump_taken, halted;
  logic [31:0] in_pc, in_instr, wb_data;
  logic [4:0]  wb_addr;
  logic [31:0] out_pc, out_rs_val, out_rt_val, out_imm, jump_target;
  logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
  logic [8:0]  out_ctrl;

  typedef struct packed {
    logic [31:0] pc, rsv, rtv, imm;
    logic [4:0]  rs, rt, rd, sh;
    logic [8:0]  ctrl;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  decode_stage_hs dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs_val(out_rs_val), .out_rt_val(out_rt_val), .out_imm(out_imm),
    .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_shamt(out_shamt),
    .out_ctrl(out_ctrl), .jump_taken(jump_taken), .jump_target(jump_target),
    .halted(halted)
  );

  always #5 clk = ~clk;

  // Monitor: every ID/EX transfer consumes one expectation.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      exp_t act, e;
      act = '{out_pc, out_rs_val, out_rt_val, out_imm, out_rs, out_rt, out_rd, out_shamt, out_ctrl};
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL idex_unexpected: got %h expected nothing", act);
      end else begin
        e = sb.pop_front();
        if (act !== e) begin
          n_err++;
          $display("FAIL idex_fields pc=%h: got %h expected %h", e.pc, act, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic ordy, input logic fl);
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
  endtask

  task automatic wb(input logic we, input logic [4:0] a, input logic [31:0] d);
    wb_we = we; wb_addr = a; wb_data = d;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] rsv, input logic [31:0] rtv,
                      input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [8:0] ctrl);
    exp_t e;
    e = '{pc, rsv, rtv, imm, rs, rt, rd, sh, ctrl};
    sb.push_back(e);
  endtask

  localparam logic [31:0] ADD_6_5_0 = 32'h00A03020;  // add r6,r5,r0
  localparam logic [31:0] ADD_7_0_0 = 32'h00003820;  // add r7,r0,r0
  localparam logic [31:0] LW_3_0_1  = 32'h8C230000;  // lw r3,0(r1)
  localparam logic [31:0] ADD_4_3_2 = 32'h00622020;  // add r4,r3,r2
  localparam logic [31:0] J_40      = 32'h08000040;
  localparam logic [31:0] JR_7      = 32'h00E00008;
  localparam logic [31:0] ADDI_9_1  = 32'h2029FFFF;  // addi r9,r1,-1
  localparam logic [31:0] HALT      = 32'hFC000000;

  initial begin
    reset = 1'b1;
    set_in(0, 0, 0, 1, 0);
    wb(0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_out_pc", out_pc, 0);
    tick();
    reset = 1'b0;

    // bypass on same-cycle write, then r0 write ignored
    set_in(1, ADD_6_5_0, 32'h104, 1, 0); wb(1, 5, 32'h1234);
    push(32'h104, 32'h1234, 0, 32'h3020, 5, 0, 6, 0, 9'h011);
    @(negedge clk); chk("in_ready_first", in_ready, 1);
    tick();
    set_in(1, ADD_7_0_0, 32'h108, 1, 0); wb(1, 0, 32'hFFFF);
    push(32'h108, 0, 0, 32'h3820, 0, 0, 7, 0, 9'h011);
    tick();
    set_in(0, 0, 0, 1, 0); wb(1, 1, 32'h40);  tick();
    wb(1, 2, 32'h5);   tick();
    wb(1, 7, 32'h200); tick();

    // load-use: one hazard cycle, one bubble, re-decode sees concurrent write
    wb(0, 0, 0);
    set_in(1, LW_3_0_1, 32'h200, 1, 0);
    push(32'h200, 32'h40, 0, 0, 1, 3, 0, 0, 9'h036);
    @(negedge clk); chk("lw_accept", in_ready, 1);
    tick();
    set_in(1, ADD_4_3_2, 32'h204, 1, 0); wb(1, 3, 32'h77);
    @(negedge clk); chk("hazard_in_ready", in_ready, 0); chk("lw_out_valid", out_valid, 1);
    tick();
    wb(0, 0, 0);
    push(32'h204, 32'h77, 32'h5, 32'h2020, 3, 2, 4, 0, 9'h011);
    @(negedge clk); chk("bubble_valid", out_valid, 0); chk("after_stall_ready", in_ready, 1);
    tick();

    // early jumps
    set_in(1, J_40, 32'h10000004, 1, 0);
    push(32'h10000004, 0, 0, 32'h40, 0, 0, 0, 1, 9'h080);
    @(negedge clk); chk("j_taken", jump_taken, 1); chk("j_target", jump_target, 32'h10000100);
    tick();
    set_in(1, JR_7, 32'h300, 1, 0);
    push(32'h300, 32'h200, 0, 32'h8, 7, 0, 0, 0, 9'h081);
    @(negedge clk); chk("jr_taken", jump_taken, 1); chk("jr_target", jump_target, 32'h200);
    tick();

    // backpressure: three held cycles, then accept when out_ready returns
    for (int i = 0; i < 3; i++) begin
      set_in(1, ADDI_9_1, 32'h400, 0, 0);
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold_pc", out_pc, 32'h300);
      chk("bp_hold_rs_val", out_rs_val, 32'h200);
      tick();
    end
    set_in(1, ADDI_9_1, 32'h400, 1, 0);
    push(32'h400, 32'h40, 0, 32'hFFFFFFFF, 1, 9, 31, 31, 9'h012);
    @(negedge clk); chk("bp_release_ready", in_ready, 1);
    tick();

    // flush while stalled behind a held load
    set_in(1, LW_3_0_1, 32'h500, 1, 0);
    @(negedge clk); chk("lw2_accept", in_ready, 1);
    tick();
    set_in(1, ADD_4_3_2, 32'h504, 0, 0);
    @(negedge clk); chk("stall_in_ready", in_ready, 0); chk("lw2_out_pc", out_pc, 32'h500);
    tick();
    set_in(1, ADD_4_3_2, 32'h504, 0, 1);
    @(negedge clk); chk("flush_in_ready", in_ready, 0); chk("flush_jump", jump_taken, 0);
    tick();
    set_in(1, ADD_4_3_2, 32'h504, 1, 0);
    push(32'h504, 32'h77, 32'h5, 32'h2020, 3, 2, 4, 0, 9'h011);
    @(negedge clk); chk("post_flush_valid", out_valid, 0); chk("post_flush_ready", in_ready, 1);
    tick();
    set_in(1, J_40, 32'h10000004, 1, 1);
    @(negedge clk); chk("flush_j_taken", jump_taken, 0);
    tick();
    set_in(0, 0, 0, 1, 0);
    @(negedge clk); chk("flush_squash_valid", out_valid, 0);
    tick();

    // halt is passed once and is sticky across flush
    set_in(1, HALT, 32'h600, 1, 0);
    push(32'h600, 0, 0, 0, 0, 0, 0, 0, 9'h000);
    @(negedge clk); chk("halt_accept", in_ready, 1);
    tick();
    set_in(1, ADD_6_5_0, 32'h604, 1, 0);
    @(negedge clk); chk("halted_set", halted, 1); chk("halted_ready", in_ready, 0);
    chk("halt_out_valid", out_valid, 1);
    tick();
    set_in(1, ADD_6_5_0, 32'h604, 1, 1);
    @(negedge clk); chk("halt_once", out_valid, 0); chk("halt_ready2", in_ready, 0);
    tick();
    set_in(1, ADD_6_5_0, 32'h604, 1, 0);
    @(negedge clk); chk("halt_after_flush", halted, 1); chk("halt_ready3", in_ready, 0);
    tick();

    reset = 1'b1;
    @(negedge clk);
    chk("rst2_halted", halted, 0); chk("rst2_valid", out_valid, 0);
    chk("rst2_pc", out_pc, 0); chk("rst2_rs_val", out_rs_val, 0); chk("rst2_ctrl", out_ctrl, 0);
    tick();
    reset = 1'b0;
    set_in(1, ADD_6_5_0, 32'h700, 1, 0);
    push(32'h700, 0, 0, 32'h3020, 5, 0, 6, 0, 9'h011);
    @(negedge clk); chk("rst2_in_ready", in_ready, 1);
    tick();
    set_in(0, 0, 0, 1, 0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
